// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, pointer/sync types and timing-total helpers.
package vga_pkg;
   localparam int H_VIS_DEF = 640;
   localparam int H_FP_DEF = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF = 48;
   localparam int V_VIS_DEF = 480;
   localparam int V_FP_DEF = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF = 33;
   typedef logic [9:0] scan_ptr_t;
   typedef struct packed {
      logic hs;
      logic vs;
      logic blank;
   } sync_bits_t;
   localparam sync_bits_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, blank: 1'b1};
   function automatic int h_tot(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction
   function automatic int v_tot(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: enabled shift register of sync bits, reset to inactive values.
module vga_sync_delay
   import vga_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  sync_bits_t d,
   output sync_bits_t q
);
   sync_bits_t pipe [DEPTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= SYNC_IDLE;
      end else if (en) begin
         pipe[0] <= d;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign q = pipe[DEPTH-1];
endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster pointer counters, delayed sync/blank, frame_start and generation tick.
module vga_scan_gen
   import vga_pkg::*;
#(
   parameter int H_VIS = H_VIS_DEF,
   parameter int H_FP = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP = H_BP_DEF,
   parameter int V_VIS = V_VIS_DEF,
   parameter int V_FP = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP = V_BP_DEF,
   parameter int SYNC_DLY = 2,
   parameter int GEN_FRAMES = 30
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      pix_en,
   input  logic      run_mode,
   output scan_ptr_t abs_ptrC,
   output scan_ptr_t abs_ptrR,
   output logic      vis,
   output logic      hsync_n,
   output logic      vsync_n,
   output logic      blank_d,
   output logic      frame_start,
   output logic      gen_tick
);
   localparam int H_TOT = h_tot(H_VIS, H_FP, H_SYNC, H_BP);
   localparam int V_TOT = v_tot(V_VIS, V_FP, V_SYNC, V_BP);
   localparam scan_ptr_t C_LAST = scan_ptr_t'(H_TOT - 1);
   localparam scan_ptr_t R_LAST = scan_ptr_t'(V_TOT - 1);
   localparam scan_ptr_t C_VIS = scan_ptr_t'(H_VIS);
   localparam scan_ptr_t R_VIS = scan_ptr_t'(V_VIS);
   localparam scan_ptr_t HS_BEG = scan_ptr_t'(H_VIS + H_FP);
   localparam scan_ptr_t HS_END = scan_ptr_t'(H_VIS + H_FP + H_SYNC);
   localparam scan_ptr_t VS_BEG = scan_ptr_t'(V_VIS + V_FP);
   localparam scan_ptr_t VS_END = scan_ptr_t'(V_VIS + V_FP + V_SYNC);
   localparam logic [7:0] G_LAST = 8'(GEN_FRAMES - 1);
   logic [7:0] gen_cnt;
   logic       c_end, r_end, wrap;
   sync_bits_t raw, dly;
   assign c_end = abs_ptrC == C_LAST;
   assign r_end = abs_ptrR == R_LAST;
   assign wrap = pix_en && c_end && r_end;
   assign vis = abs_ptrC < C_VIS && abs_ptrR < R_VIS;
   always_comb begin
      raw.hs = abs_ptrC >= HS_BEG && abs_ptrC < HS_END;
      raw.vs = abs_ptrR >= VS_BEG && abs_ptrR < VS_END;
      raw.blank = !vis;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         abs_ptrC <= '0;
         abs_ptrR <= '0;
         frame_start <= 1'b0;
         gen_tick <= 1'b0;
         gen_cnt <= '0;
      end else begin
         frame_start <= wrap;
         gen_tick <= wrap && run_mode && gen_cnt == G_LAST;
         if (pix_en) abs_ptrC <= c_end ? '0 : abs_ptrC + 1'b1;
         if (pix_en && c_end) abs_ptrR <= r_end ? '0 : abs_ptrR + 1'b1;
         // counting happens at the wrap edge so gen_tick lands with frame_start
         if (wrap && run_mode) gen_cnt <= gen_cnt == G_LAST ? '0 : gen_cnt + 1'b1;
      end
   end
   vga_sync_delay #(.DEPTH(SYNC_DLY)) u_dly (
      .clk(clk),
      .rst(rst),
      .en(pix_en),
      .d(raw),
      .q(dly)
   );
   assign hsync_n = !dly.hs;
   assign vsync_n = !dly.vs;
   assign blank_d = dly.blank;
endmodule
